// File: rtl/ram_bitfield_extract_ctrl.sv
// Bit-field extraction sequencer for the 32-bit RAM bit-select mux.
// Latches one RAM word plus a field descriptor, walks the mux select across
// the field one bit per clock and returns the right-aligned, optionally
// sign-extended field with a truncation flag.
module ram_bitfield_extract_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = 5,
    parameter int FIELD_MAX  = 16,
    parameter int LEN_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [SEL_WIDTH-1:0]  in_start,
    input  logic [LEN_WIDTH-1:0]  in_len,
    input  logic                  in_signed,
    output logic [DATA_WIDTH-1:0] mux_data,
    output logic [SEL_WIDTH-1:0]  mux_sel,
    input  logic                  mux_bit,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [FIELD_MAX-1:0]  out_data,
    output logic                  out_err
);

    localparam int POS_W = SEL_WIDTH + 1;
    localparam logic [LEN_WIDTH-1:0] FMAX_L  = LEN_WIDTH'(FIELD_MAX);
    localparam logic [POS_W-1:0]     DW_P    = POS_W'(DATA_WIDTH);
    localparam logic [SEL_WIDTH-1:0] SEL_MAX = SEL_WIDTH'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  mux_data_q, mux_data_d;
    logic [SEL_WIDTH-1:0]   mux_sel_q, mux_sel_d;
    logic [SEL_WIDTH-1:0]   start_q, start_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [LEN_WIDTH-1:0]   idx_q, idx_d;
    logic [FIELD_MAX-1:0]   acc_q, acc_d;
    logic                   err_q, err_d;
    logic                   signed_q, signed_d;
    logic                   in_ready_q, in_ready_d;
    logic                   out_valid_q, out_valid_d;
    logic [FIELD_MAX-1:0]   out_data_q, out_data_d;
    logic                   out_err_q, out_err_d;

    logic [LEN_WIDTH-1:0]   len_eff;
    logic                   req_err;
    logic [POS_W-1:0]       pos;
    logic                   bit_in;
    logic                   sign_bit;
    logic [FIELD_MAX-1:0]   field;

    // Decode the incoming descriptor: clamp the length and flag truncation.
    always_comb begin
        len_eff = (in_len > FMAX_L) ? FMAX_L : in_len;
        req_err = (in_len > FMAX_L) ||
                  (({1'b0, in_start} + POS_W'(len_eff)) > DW_P);
    end

    // Mask bits past the top of the word and build the sign-extended field.
    always_comb begin
        pos      = {1'b0, start_q} + POS_W'(idx_q);
        bit_in   = (pos < DW_P) ? mux_bit : 1'b0;
        sign_bit = 1'b0;
        for (int unsigned i = 0; i < FIELD_MAX; i++) begin
            if (LEN_WIDTH'(i + 1) == len_q) sign_bit = acc_q[i];
        end
        // With len_q == 0 sign_bit stays 0, so a signed empty field is all zero.
        field = acc_q;
        if (signed_q) begin
            for (int unsigned i = 0; i < FIELD_MAX; i++) begin
                if (LEN_WIDTH'(i) >= len_q) field[i] = sign_bit;
            end
        end
    end

    // Next-state and registered-output logic for the IDLE/SHIFT/DONE sequencer.
    always_comb begin
        state_d     = state_q;
        mux_data_d  = mux_data_q;
        mux_sel_d   = mux_sel_q;
        start_d     = start_q;
        len_d       = len_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        err_d       = err_q;
        signed_d    = signed_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    mux_data_d = in_data;
                    mux_sel_d  = in_start;
                    start_d    = in_start;
                    len_d      = len_eff;
                    err_d      = req_err;
                    signed_d   = in_signed;
                    acc_d      = '0;
                    idx_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = (len_eff != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                for (int unsigned i = 0; i < FIELD_MAX; i++) begin
                    if (LEN_WIDTH'(i) == idx_q) acc_d[i] = bit_in;
                end
                idx_d = idx_q + 1'b1;
                if ((idx_q + 1'b1) == len_q) begin
                    state_d = DONE;
                end else if (mux_sel_q != SEL_MAX) begin
                    mux_sel_d = mux_sel_q + 1'b1;
                end
            end
            DONE: begin
                // First DONE cycle publishes the result; afterwards wait for hand-off.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_data_d  = field;
                    out_err_d   = err_q;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with asynchronous abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mux_data_q  <= '0;
            mux_sel_q   <= '0;
            start_q     <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            acc_q       <= '0;
            err_q       <= 1'b0;
            signed_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mux_data_q  <= mux_data_d;
            mux_sel_q   <= mux_sel_d;
            start_q     <= start_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            err_q       <= err_d;
            signed_q    <= signed_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign mux_data  = mux_data_q;
    assign mux_sel   = mux_sel_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_ram_bitfield_extract_ctrl.sv
// Self-checking bench for ram_bitfield_extract_ctrl: directed cases plus
// randomized requests compared against an arithmetic field-extraction model.
module tb_ram_bitfield_extract_ctrl;

    localparam int DW = 32;
    localparam int SW = 5;
    localparam int FM = 16;
    localparam int LW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [SW-1:0] in_start;
    logic [LW-1:0] in_len;
    logic          in_signed;
    logic [DW-1:0] mux_data;
    logic [SW-1:0] mux_sel;
    logic          mux_bit;
    logic          out_valid;
    logic          out_ready;
    logic [FM-1:0] out_data;
    logic          out_err;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    ram_bitfield_extract_ctrl #(
        .DATA_WIDTH(DW),
        .SEL_WIDTH (SW),
        .FIELD_MAX (FM),
        .LEN_WIDTH (LW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_start (in_start),
        .in_len   (in_len),
        .in_signed(in_signed),
        .mux_data (mux_data),
        .mux_sel  (mux_sel),
        .mux_bit  (mux_bit),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_err  (out_err)
    );

    // Combinational 32:1 bit-select mux sitting next to the controller.
    assign mux_bit = mux_data[mux_sel];

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: {err, field} from shift/mask arithmetic on the word.
    function automatic logic [16:0] model(input logic [31:0] d, input int unsigned st,
                                          input int unsigned ln, input logic sg);
        int unsigned le;
        logic [63:0] w;
        logic [16:0] full;
        logic [15:0] mask;
        logic [15:0] f;
        logic        e;
        le   = (ln > 16) ? 16 : ln;
        w    = {32'b0, d} >> st;
        full = (17'd1 << le) - 17'd1;
        mask = full[15:0];
        f    = w[15:0] & mask;
        if (sg && le > 0 && f[le-1]) f = f | ~mask;
        e = (ln > 16) || (st + le > 32);
        return {e, f};
    endfunction

    task automatic run_req(input logic [31:0] d, input int unsigned st, input int unsigned ln,
                           input logic sg, input int unsigned hold);
        logic [16:0] m;
        int unsigned le;
        int unsigned edges;
        int unsigned exp_sel;
        m  = model(d, st, ln, sg);
        le = (ln > 16) ? 16 : ln;
        edges = 0;
        while (!in_ready && edges < 50) begin
            tick();
            edges++;
        end
        check_val("in_ready_idle", in_ready, 1);
        in_valid  = 1'b1;
        in_data   = d;
        in_start  = SW'(st);
        in_len    = LW'(ln);
        in_signed = sg;
        out_ready = (hold == 0);
        tick();
        in_valid  = 1'b0;
        in_data   = $urandom;
        in_start  = SW'($urandom);
        in_len    = LW'($urandom);
        check_val("in_ready_busy", in_ready, 0);
        check_val("mux_data_latched", mux_data, d);
        edges = 0;
        while (!out_valid && edges < 40) begin
            if (edges < le) begin
                exp_sel = (st + edges > 31) ? 31 : st + edges;
                check_val("mux_sel_step", mux_sel, exp_sel);
            end
            tick();
            edges++;
        end
        check_val("latency", edges, le + 1);
        check_val("out_data", out_data, m[15:0]);
        check_val("out_err", out_err, m[16]);
        if (hold > 0) begin
            for (int k = 0; k < int'(hold); k++) begin
                in_valid = 1'b1;
                in_data  = ~d;
                in_len   = LW'(1);
                tick();
                check_val("bp_valid", out_valid, 1);
                check_val("bp_data", out_data, m[15:0]);
                check_val("bp_err", out_err, m[16]);
                check_val("bp_in_ready", in_ready, 0);
                check_val("bp_mux_data", mux_data, d);
            end
            out_ready = 1'b1;
        end
        tick();
        in_valid = 1'b0;
        check_val("handoff_valid_low", out_valid, 0);
        check_val("handoff_in_ready", in_ready, 1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_start  = '0;
        in_len    = '0;
        in_signed = 1'b0;
        out_ready = 1'b1;
        #3;
        check_val("rst_in_ready", in_ready, 1);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_out_data", out_data, 0);
        check_val("rst_out_err", out_err, 0);
        check_val("rst_mux_data", mux_data, 0);
        check_val("rst_mux_sel", mux_sel, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        run_req(32'hDEADBEEF, 4, 8, 1'b0, 0);
        run_req(32'hDEADBEEF, 4, 8, 1'b1, 0);
        run_req(32'hDEADBEEF, 0, 4, 1'b1, 0);
        run_req(32'hDEADBEEF, 28, 8, 1'b0, 0);
        run_req(32'h000F1234, 0, 20, 1'b0, 0);
        run_req(32'hDEADBEEF, 5, 0, 1'b1, 0);
        run_req(32'hDEADBEEF, 4, 8, 1'b1, 5);
        run_req(32'hFFFFFFFF, 31, 16, 1'b1, 0);

        // Abort mid-shift with an asynchronous reset.
        in_valid  = 1'b1;
        in_data   = 32'hDEADBEEF;
        in_start  = SW'(4);
        in_len    = LW'(8);
        in_signed = 1'b0;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        #1;
        rst = 1'b1;
        #1;
        check_val("abort_in_ready", in_ready, 1);
        check_val("abort_out_valid", out_valid, 0);
        check_val("abort_out_data", out_data, 0);
        check_val("abort_out_err", out_err, 0);
        check_val("abort_mux_data", mux_data, 0);
        check_val("abort_mux_sel", mux_sel, 0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            check_val("abort_no_result", out_valid, 0);
        end
        run_req(32'hDEADBEEF, 4, 8, 1'b0, 0);

        for (int t = 0; t < 150; t++) begin
            logic [31:0]  d;
            int unsigned  st;
            int unsigned  ln;
            logic         sg;
            int unsigned  hold;
            d    = $urandom;
            st   = $urandom_range(0, 31);
            ln   = $urandom_range(0, 31);
            sg   = 1'($urandom_range(0, 1));
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            run_req(d, st, ln, sg, hold);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
